// File: rtl/audio_sequencer.sv
// Beat scheduler for the melody/bass synth: counts frame ticks, fetches one song ROM row per beat,
// advances the song position and drives the per-voice decaying envelopes.
module audio_sequencer #(
    parameter int unsigned SONG_LEN       = 288,
    parameter int unsigned TICKS_PER_BEAT = 6,
    parameter int unsigned POS_W          = 9,
    parameter int unsigned VOL_W          = 6,
    parameter int unsigned MEL_DECAY_SH   = 3,
    parameter int unsigned BASS_DECAY_SH  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_tick,
    input  logic             run,
    input  logic             restart,
    output logic             rom_en,
    output logic [POS_W-1:0] rom_addr,
    input  logic             rom_mel_trig,
    input  logic             rom_bass_trig,
    output logic [POS_W-1:0] songpos,
    output logic             beat_strobe,
    output logic [VOL_W-1:0] mel_vol,
    output logic [VOL_W-1:0] bass_vol,
    output logic             busy
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_BEAT + 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(SONG_LEN - 1);
    localparam logic [VOL_W-1:0]  VOL_MAX   = {VOL_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StApply
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_ctr;
    logic [VOL_W-1:0]  mel_q;
    logic [VOL_W-1:0]  bass_q;

    // Shift-based decay never underflows; it stalls once vol >> sh reaches zero.
    logic [VOL_W-1:0] mel_decayed;
    logic [VOL_W-1:0] bass_decayed;

    always_comb begin
        mel_decayed  = mel_q - (mel_q >> MEL_DECAY_SH);
        bass_decayed = bass_q - (bass_q >> BASS_DECAY_SH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            state       <= StIdle;
            tick_ctr    <= '0;
            songpos     <= LAST_POS;
            rom_addr    <= LAST_POS;
            rom_en      <= 1'b0;
            beat_strobe <= 1'b0;
            mel_q       <= '0;
            bass_q      <= '0;
        end else begin
            rom_en      <= 1'b0;
            beat_strobe <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (frame_tick && run) begin
                        if (tick_ctr == LAST_TICK) begin
                            tick_ctr <= '0;
                            rom_en   <= 1'b1;
                            rom_addr <= songpos;
                            state    <= StFetch;
                        end else begin
                            tick_ctr <= tick_ctr + TICK_W'(1);
                            mel_q    <= mel_decayed;
                            bass_q   <= bass_decayed;
                        end
                    end
                end
                StFetch: begin
                    // Strobe coincides with the cycle the ROM data is valid.
                    beat_strobe <= 1'b1;
                    state       <= StApply;
                end
                StApply: begin
                    if (rom_mel_trig) begin
                        mel_q <= VOL_MAX;
                    end
                    if (rom_bass_trig) begin
                        bass_q <= VOL_MAX;
                    end
                    songpos <= (songpos == LAST_POS) ? '0 : songpos + POS_W'(1);
                    state   <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy     = (state != StIdle);
        mel_vol  = run ? mel_q : '0;
        bass_vol = run ? bass_q : '0;
    end

endmodule
